// File: rtl/pls_pkg.sv
// Shared types and constants for the 10BASE-T PLS transmit and receive halves.
package pls_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        DATA = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        SP_VIOL = 2'd0,
        SP_BND  = 2'd1,
        SP_MID  = 2'd2
    } sp_class_e;

    localparam int unsigned TC_W = 5;
    typedef logic [TC_W-1:0] tcount_t;

    // Transition spacing windows, in 80 MHz samples.
    localparam tcount_t SP_BND_MIN = 5'd3;
    localparam tcount_t SP_BND_MAX = 5'd5;
    localparam tcount_t SP_MID_MIN = 5'd6;
    localparam tcount_t SP_MID_MAX = 5'd10;
    localparam tcount_t SP_QUIET   = 5'd12;
    localparam tcount_t TC_SAT     = 5'd31;

    localparam int unsigned NLP_PERIOD_CYC = 320000;

    function automatic tcount_t tc_inc(input tcount_t t);
        return (t == TC_SAT) ? t : t + 5'd1;
    endfunction

    function automatic sp_class_e sp_class(input tcount_t t);
        if (t >= SP_MID_MIN && t <= SP_MID_MAX) return SP_MID;
        if (t >= SP_BND_MIN && t <= SP_BND_MAX) return SP_BND;
        return SP_VIOL;
    endfunction

endpackage

// File: rtl/pls_rx_edge.sv
// Transition finder over the 5-sample window {held sample, rxd_in[3:0]}.
// Index k is the k-th position in time order (0 = oldest).
module pls_rx_edge (
    input  logic       prev_i,
    input  logic [3:0] rxd_i,
    output logic [3:0] trans_o,
    output logic [3:0] lvl_o
);

    logic [4:0] win;

    assign win = {prev_i, rxd_i};

    always_comb begin
        trans_o = '0;
        lvl_o   = '0;
        for (int k = 0; k < 4; k++) begin
            trans_o[k] = win[4-k] ^ win[3-k];
            lvl_o[k]   = win[3-k];
        end
    end

endmodule

// File: rtl/pls_rx.sv
// 10BASE-T PLS receiver: Manchester decode, carrier sense and NLP link integrity.
module pls_rx #(
    parameter int unsigned LINK_MIN_CYC = 40000,
    parameter int unsigned LINK_MAX_CYC = 2000000,
    parameter int unsigned LINK_PULSES  = 2
) (
    input  logic       clk_20mhz,
    input  logic       rst_i,
    input  logic [3:0] rxd_in,
    output logic       rxd_out,
    output logic       rxd_valid,
    output logic       carrier,
    output logic       rx_err,
    output logic       link_ok
);

    import pls_pkg::*;

    localparam int unsigned LCW = $clog2(LINK_MAX_CYC + 1);
    localparam int unsigned GDW = $clog2(LINK_PULSES + 1);
    localparam logic [LCW-1:0] LINK_MIN_V = LCW'(LINK_MIN_CYC);
    localparam logic [LCW-1:0] LINK_MAX_V = LCW'(LINK_MAX_CYC);
    localparam logic [GDW-1:0] GOOD_MAX_V = GDW'(LINK_PULSES);

    rx_state_e      state_q, state_d;
    tcount_t        tcount_q, tcount_d;
    logic [1:0]     acq_q, acq_d;
    logic           prev_q;
    logic           rxd_out_q, rxd_valid_q, carrier_q, rx_err_q, link_ok_q;
    logic           rxd_out_d, link_ok_d;
    logic [LCW-1:0] link_cnt_q, link_cnt_d;
    logic [GDW-1:0] good_q, good_d;

    logic [3:0]     trans, lvl;
    logic           emit_d, bit_d, err_d, nlp_d, stop_c;

    pls_rx_edge u_edge (
        .prev_i  (prev_q),
        .rxd_i   (rxd_in),
        .trans_o (trans),
        .lvl_o   (lvl)
    );

    // Walk the four positions oldest-first; state carries across positions.
    always_comb begin
        state_d  = state_q;
        tcount_d = tcount_q;
        acq_d    = acq_q;
        emit_d   = 1'b0;
        bit_d    = 1'b0;
        err_d    = 1'b0;
        nlp_d    = 1'b0;
        stop_c   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!stop_c) begin
                tcount_d = tc_inc(tcount_d);
                case (state_d)
                    IDLE: begin
                        if (trans[k] && lvl[k]) begin
                            tcount_d = '0;
                            acq_d    = 2'd1;
                            state_d  = ARM;
                        end
                    end
                    ARM: begin
                        if (trans[k]) begin
                            if (sp_class(tcount_d) == SP_MID) begin
                                tcount_d = '0;
                                acq_d    = acq_d + 2'd1;
                                if (acq_d == 2'd3) state_d = DATA;
                            end else begin
                                state_d = IDLE;
                            end
                        end else if (tcount_d > SP_QUIET) begin
                            // A lone high pulse of preamble width followed by silence is an NLP.
                            if (acq_d == 2'd2 && !lvl[k]) nlp_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    DATA: begin
                        if (trans[k]) begin
                            case (sp_class(tcount_d))
                                SP_MID: begin
                                    emit_d   = 1'b1;
                                    bit_d    = lvl[k];
                                    tcount_d = '0;
                                end
                                SP_BND: begin
                                end
                                default: begin
                                    err_d   = 1'b1;
                                    state_d = IDLE;
                                    stop_c  = 1'b1;
                                end
                            endcase
                        end else if (tcount_d > SP_QUIET) begin
                            if (!lvl[k]) err_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign rxd_out_d = emit_d ? bit_d : rxd_out_q;

    always_comb begin
        link_cnt_d = link_cnt_q;
        good_d     = good_q;
        link_ok_d  = link_ok_q;
        if (link_cnt_q != LINK_MAX_V) link_cnt_d = link_cnt_q + LCW'(1);
        if (link_cnt_q == LINK_MAX_V) begin
            good_d    = '0;
            link_ok_d = 1'b0;
        end
        if (nlp_d) begin
            if (link_cnt_q >= LINK_MIN_V) begin
                if (good_d != GOOD_MAX_V) good_d = good_d + GDW'(1);
            end else begin
                good_d = '0;
            end
            link_cnt_d = '0;
        end
        if (carrier_q) link_cnt_d = '0;
        if (good_d == GOOD_MAX_V) link_ok_d = 1'b1;
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tcount_q    <= '0;
            acq_q       <= '0;
            prev_q      <= 1'b0;
            rxd_out_q   <= 1'b0;
            rxd_valid_q <= 1'b0;
            carrier_q   <= 1'b0;
            rx_err_q    <= 1'b0;
            link_cnt_q  <= '0;
            good_q      <= '0;
            link_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcount_q    <= tcount_d;
            acq_q       <= acq_d;
            prev_q      <= rxd_in[0];
            rxd_out_q   <= rxd_out_d;
            rxd_valid_q <= emit_d;
            carrier_q   <= (state_d == DATA);
            rx_err_q    <= err_d;
            link_cnt_q  <= link_cnt_d;
            good_q      <= good_d;
            link_ok_q   <= link_ok_d;
        end
    end

    assign rxd_out   = rxd_out_q;
    assign rxd_valid = rxd_valid_q;
    assign carrier   = carrier_q;
    assign rx_err    = rx_err_q;
    assign link_ok   = link_ok_q;

endmodule

// File: tb/tb_pls_rx.sv
// Directed bench for pls_rx: Manchester frames from a sample stream, expected bits scoreboarded.
`timescale 1ns/1ps
module tb_pls_rx;

    import pls_pkg::*;

    localparam int unsigned MIN_C   = 200;
    localparam int unsigned MAX_C   = 2500;
    localparam int          NLP_GAP = NLP_PERIOD_CYC / 800;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rxd = 4'd0;
    logic       rxd_out, rxd_valid, carrier, rx_err, link_ok;

    always #25 clk = ~clk;

    pls_rx #(
        .LINK_MIN_CYC (MIN_C),
        .LINK_MAX_CYC (MAX_C),
        .LINK_PULSES  (2)
    ) dut (
        .clk_20mhz (clk),
        .rst_i     (rst),
        .rxd_in    (rxd),
        .rxd_out   (rxd_out),
        .rxd_valid (rxd_valid),
        .carrier   (carrier),
        .rx_err    (rx_err),
        .link_ok   (link_ok)
    );

    int n_cmp = 0, n_bad = 0;
    int n_valid = 0, n_err = 0, n_car = 0;
    int bidx = 0;
    bit stream[$];
    bit exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rxd_valid) begin
                n_valid++;
                chk("bit_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("rxd_out", 32'(rxd_out), 32'(exp_q.pop_front()));
            end
            if (rx_err) begin
                n_err++;
                chk("carrier_low_on_err", 32'(carrier), 0);
            end
            if (carrier) n_car++;
        end
    end

    task automatic add_lvl(input bit l, input int n);
        repeat (n) stream.push_back(l);
    endtask

    // Manchester cell of p samples: inverse half first, value half second.
    task automatic add_bit(input bit b, input int p);
        add_lvl(~b, p / 2);
        add_lvl(b, p - p / 2);
        if (bidx >= 3) exp_q.push_back(b);
        bidx++;
    endtask

    task automatic add_byte(input logic [7:0] v, input int p);
        for (int i = 0; i < 8; i++) add_bit(v[i], p);
    endtask

    task automatic add_hdr(input int p);
        bidx = 0;
        for (int i = 0; i < 56; i++) add_bit(i % 2 == 0, p);
        add_byte(8'hD5, p);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            logic [3:0] s;
            for (int k = 0; k < 4; k++) s[3-k] = (stream.size() != 0) ? stream.pop_front() : 1'b0;
            rxd = s;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        run((stream.size() + 3) / 4 + 8);
    endtask

    task automatic nlp();
        add_lvl(1'b1, 8);
        add_lvl(1'b0, 16);
        run(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int v0, e0, c0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rxd_out", 32'(rxd_out), 0);
        chk("rst_rxd_valid", 32'(rxd_valid), 0);
        chk("rst_carrier", 32'(carrier), 0);
        chk("rst_rx_err", 32'(rx_err), 0);
        chk("rst_link_ok", 32'(link_ok), 0);
        rst = 1'b0;

        // clean frame, 8 samples/bit, ETD high
        v0 = n_valid; e0 = n_err;
        add_hdr(8); add_byte(8'h3C, 8); add_byte(8'hA5, 8); add_lvl(1'b1, 16);
        run(8);
        chk("f8_carrier_up", 32'(carrier), 1);
        drain();
        chk("f8_bits", n_valid - v0, 77);
        chk("f8_left", exp_q.size(), 0);
        chk("f8_err", n_err - e0, 0);
        chk("f8_carrier_down", 32'(carrier), 0);

        // 2-sample glitch right after a mid-bit in the same cycle
        v0 = n_valid; e0 = n_err;
        add_hdr(8); add_byte(8'h96, 8);
        add_lvl(1'b1, 4); add_lvl(1'b0, 1); add_lvl(1'b1, 2); add_lvl(1'b0, 1);
        exp_q.push_back(1'b0);
        drain();
        chk("glitch_err", n_err - e0, 1);
        chk("glitch_bits", n_valid - v0, 70);
        chk("glitch_left", exp_q.size(), 0);
        chk("glitch_carrier", 32'(carrier), 0);

        // frame ending low
        v0 = n_valid; e0 = n_err;
        add_hdr(8); add_byte(8'h5A, 8);
        drain();
        chk("etdlow_err", n_err - e0, 1);
        chk("etdlow_bits", n_valid - v0, 69);
        chk("etdlow_left", exp_q.size(), 0);
        chk("etdlow_carrier", 32'(carrier), 0);

        // jitter: 7 and 9 samples per bit
        v0 = n_valid; e0 = n_err;
        add_hdr(7); add_byte(8'hC3, 7); add_byte(8'h5E, 7); add_lvl(1'b1, 16);
        drain();
        chk("p7_bits", n_valid - v0, 77);
        chk("p7_left", exp_q.size(), 0);
        chk("p7_err", n_err - e0, 0);
        v0 = n_valid; e0 = n_err;
        add_hdr(9); add_byte(8'h1B, 9); add_byte(8'hE4, 9); add_lvl(1'b1, 16);
        drain();
        chk("p9_bits", n_valid - v0, 77);
        chk("p9_left", exp_q.size(), 0);
        chk("p9_err", n_err - e0, 0);

        // reset mid-frame
        e0 = n_err;
        add_hdr(8); add_byte(8'hFF, 8);
        run(40);
        chk("mid_carrier_up", 32'(carrier), 1);
        do_reset();
        chk("mid_rst_rxd_out", 32'(rxd_out), 0);
        chk("mid_rst_rxd_valid", 32'(rxd_valid), 0);
        chk("mid_rst_carrier", 32'(carrier), 0);
        chk("mid_rst_rx_err", 32'(rx_err), 0);
        chk("mid_rst_link_ok", 32'(link_ok), 0);
        stream.delete();
        exp_q.delete();
        run(10);
        chk("mid_rst_no_err", n_err - e0, 0);

        // two well-spaced NLPs
        do_reset();
        v0 = n_valid; c0 = n_car;
        run(NLP_GAP); nlp();
        chk("nlp1_link", 32'(link_ok), 0);
        run(NLP_GAP); nlp();
        chk("nlp2_link", 32'(link_ok), 1);
        chk("nlp_no_valid", n_valid - v0, 0);
        chk("nlp_no_carrier", n_car - c0, 0);

        // NLPs too close together never qualify
        do_reset();
        run(NLP_GAP); nlp();
        chk("close0_link", 32'(link_ok), 0);
        for (int i = 0; i < 3; i++) begin
            run(50); nlp();
            chk("close_link", 32'(link_ok), 0);
        end
        run(NLP_GAP); nlp();
        chk("regood1_link", 32'(link_ok), 0);
        run(NLP_GAP); nlp();
        chk("regood2_link", 32'(link_ok), 1);

        // link loss after silence
        run(MAX_C - 10);
        chk("pre_timeout_link", 32'(link_ok), 1);
        run(20);
        chk("timeout_link", 32'(link_ok), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
